spi_pwm_config: RTL and testbench
=================================

// Module: spi_pwm_config
// PURPOSE
//  SPI slave (mode 0, write-only) that programs the five configuration registers of the PWM peripheral.
//  Sits between the SPI pins on ui_in and pwm_peripheral; its outputs drive en_reg_out_*, en_reg_pwm_*
//  and pwm_duty_cycle directly. SPI inputs are asynchronous to clk and are oversampled/synchronised;
//  all logic runs in the clk domain.
// PARAMETERS
//  SYNC_STAGES  2      flops per input synchroniser (>=2)
//  MAX_ADDR     7'h04  highest valid register address; writes above it are dropped
// PORTS
//  clk              in   1  system clock
//  rst_n            in   1  asynchronous, active-low reset
//  sclk             in   1  SPI clock (async), idle low, sample on rising edge
//  copi             in   1  SPI data in (async), MSB first
//  ncs              in   1  SPI chip select (async), active low, frames one transaction
//  en_reg_out_7_0   out  8  addr 0x00: output enables, pins 7:0
//  en_reg_out_15_8  out  8  addr 0x01: output enables, pins 15:8
//  en_reg_pwm_7_0   out  8  addr 0x02: PWM mode enables, pins 7:0
//  en_reg_pwm_15_8  out  8  addr 0x03: PWM mode enables, pins 15:8
//  pwm_duty_cycle   out  8  addr 0x04: duty cycle (0x00 = 0 %, 0xFF = 100 %)
//  wr_done          out  1  1-cycle pulse when a register is committed
// BEHAVIOUR
//  - One clock (clk); reset is asynchronous and active-low (rst_n). Reset: all five regs 8'h00,
//    wr_done 0, FSM IDLE, bit count 0, shift reg 0, synchronisers cleared (ncs sync chain resets to 1).
//  - sclk/copi/ncs each pass through SYNC_STAGES flops; one extra flop per signal for edge detection.
//    Requirement: clk >= 4x sclk, with sclk high and low each >= 2 clk periods.
//  - Frame: 16 bits, MSB first: [15]=R/W (1=write), [14:8]=address, [7:0]=data.
//  - FSM states IDLE, SHIFT, COMMIT:
//    IDLE   -> SHIFT on synced ncs falling edge; clear bit count and shift reg.
//    SHIFT  : on each synced sclk rising edge, shift_reg <= {shift_reg[14:0], copi_s}; count++.
//             Count saturates at 16; further edges are ignored (no shift).
//             On synced ncs rising edge: -> COMMIT if count==16, else -> IDLE (frame discarded).
//    COMMIT : one cycle. If shift_reg[15]==1 and addr<=MAX_ADDR, write data to the addressed register
//             and pulse wr_done. Otherwise nothing changes. Always -> IDLE.
//  - Latency: register and wr_done update SYNC_STAGES+2 clk cycles after the ncs pin rises (+/-1 for
//    sampling phase). Registers hold value between writes; no read-back path. Read frames are ignored.
//  - Simultaneous synced sclk rise and ncs rise in the same cycle: ncs wins; that sclk edge is not shifted.
//  - ncs falling while in SHIFT (missed rise) restarts the frame: count cleared, shift reg cleared.
//  - sclk edges while ncs high are ignored.
//  - rst_n asserted mid-frame aborts it; all registers return to 0 regardless of frame progress.
//  - Address width 7 bits compared unsigned; 0x05..0x7F never alter any register.
// STRUCTURE
//  - Shared package/header spi_pwm_pkg: FRAME_BITS=16, ADDR_* localparams (0x00..0x04), FSM state encoding.
//  - Sub-module spi_sync (SYNC_STAGES-deep synchroniser, parameterised reset value), instantiated 3x.
//  - Top instantiates spi_pwm_config next to pwm_peripheral; ui_in[0]=sclk, ui_in[1]=copi, ui_in[2]=ncs.
// TESTING
//  1 Reset: hold rst_n low 5 cycles -> all five regs 8'h00, wr_done 0; no sclk activity changes them.
//  2 Write frame 0x80F0 (addr 0x00, data 0xF0) at clk/8 -> en_reg_out_7_0==8'hF0 within SYNC_STAGES+3
//    cycles of ncs rise, one wr_done pulse, other regs unchanged.
//  3 Write 0x8480 (addr 0x04) -> pwm_duty_cycle==8'h80; then 0x0455 (read bit 0) -> remains 8'h80, no wr_done.
//  4 Write 0x8755 (addr 0x07 > MAX_ADDR) -> no register changes, no wr_done.
//  5 Truncated frame: 12 sclk edges then ncs high -> discarded; next full frame 0x8233 sets en_reg_pwm_7_0=8'h33.
//  6 17-bit frame (extra trailing edge) -> first 16 bits committed; rst_n pulsed mid-frame -> all regs 0, FSM IDLE.

Source files
------------

// File: rtl/spi_pwm_pkg.sv
// Shared definitions for the SPI configuration port of the PWM peripheral:
// frame geometry, register map and controller state encoding.
package spi_pwm_pkg;

   localparam int FRAME_BITS = 16;
   localparam int CNT_W      = 5;

   localparam logic [6:0] ADDR_EN_OUT_LO = 7'h00;
   localparam logic [6:0] ADDR_EN_OUT_HI = 7'h01;
   localparam logic [6:0] ADDR_EN_PWM_LO = 7'h02;
   localparam logic [6:0] ADDR_EN_PWM_HI = 7'h03;
   localparam logic [6:0] ADDR_DUTY      = 7'h04;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SHIFT  = 2'd1,
      ST_COMMIT = 2'd2
   } spi_state_e;

   // A frame is a write only when its leading bit is set.
   function automatic logic is_write(input logic [FRAME_BITS-1:0] frame);
      return frame[FRAME_BITS-1];
   endfunction

endpackage

// File: rtl/spi_pwm_if.sv
// SPI pin group plus the configuration register outputs it programs.
// Protocol: no valid/ready pair exists; a register value is new exactly in the cycle wr_done is high.
interface spi_pwm_if;
   logic       sclk;
   logic       copi;
   logic       ncs;
   logic [7:0] en_reg_out_7_0;
   logic [7:0] en_reg_out_15_8;
   logic [7:0] en_reg_pwm_7_0;
   logic [7:0] en_reg_pwm_15_8;
   logic [7:0] pwm_duty_cycle;
   logic       wr_done;

   modport master (
      output sclk, copi, ncs,
      input  en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8,
             pwm_duty_cycle, wr_done
   );

   modport slave (
      input  sclk, copi, ncs,
      output en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8,
             pwm_duty_cycle, wr_done
   );
endinterface

// File: rtl/spi_sync.sv
// Multi-flop synchroniser for one asynchronous input, with a selectable reset value.
module spi_sync #(
   parameter int   STAGES  = 2,
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] chain;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         chain <= {STAGES{RST_VAL}};
      end else begin
         chain <= {chain[STAGES-2:0], d};
      end
   end

   assign q = chain[STAGES-1];

endmodule

// File: rtl/spi_pwm_config.sv
// Write-only SPI mode-0 slave that loads the five PWM peripheral configuration
// registers from 16-bit frames {write, addr[6:0], data[7:0]}.
module spi_pwm_config
   import spi_pwm_pkg::*;
#(
   parameter int         SYNC_STAGES = 2,
   parameter logic [6:0] MAX_ADDR    = 7'h04
) (
   input  logic       clk,
   input  logic       rst_n,
   spi_pwm_if.slave   bus,
   output spi_state_e state_dbg
);

   logic sclk_s, copi_s, ncs_s;
   logic sclk_d, ncs_d;
   logic sclk_rise, ncs_rise, ncs_fall;

   spi_state_e state_q, state_nxt;
   logic [CNT_W-1:0]      bit_cnt_q;
   logic [FRAME_BITS-1:0] shift_q;
   logic                  clr_frame, do_shift, do_commit;

   logic [7:0] en_out_lo_q, en_out_hi_q, en_pwm_lo_q, en_pwm_hi_q, duty_q;
   logic       wr_done_q;

   logic [6:0] frame_addr;
   logic [7:0] frame_data;

   spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
      .clk(clk), .rst_n(rst_n), .d(bus.sclk), .q(sclk_s)
   );
   spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_copi (
      .clk(clk), .rst_n(rst_n), .d(bus.copi), .q(copi_s)
   );
   spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ncs (
      .clk(clk), .rst_n(rst_n), .d(bus.ncs), .q(ncs_s)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sclk_d <= 1'b0;
         ncs_d  <= 1'b1;
      end else begin
         sclk_d <= sclk_s;
         ncs_d  <= ncs_s;
      end
   end

   assign sclk_rise = sclk_s & ~sclk_d;
   assign ncs_rise  = ncs_s & ~ncs_d;
   assign ncs_fall  = ~ncs_s & ncs_d;

   assign frame_addr = shift_q[14:8];
   assign frame_data = shift_q[7:0];

   // Chip-select edges take priority over sclk so a coincident final edge is dropped.
   always_comb begin
      state_nxt = state_q;
      clr_frame = 1'b0;
      do_shift  = 1'b0;
      do_commit = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (ncs_fall) begin
               state_nxt = ST_SHIFT;
               clr_frame = 1'b1;
            end
         end
         ST_SHIFT: begin
            if (ncs_fall) begin
               clr_frame = 1'b1;
            end else if (ncs_rise) begin
               state_nxt = (bit_cnt_q == CNT_W'(FRAME_BITS)) ? ST_COMMIT : ST_IDLE;
            end else if (sclk_rise && (bit_cnt_q != CNT_W'(FRAME_BITS))) begin
               do_shift = 1'b1;
            end
         end
         ST_COMMIT: begin
            state_nxt = ST_IDLE;
            do_commit = is_write(shift_q) && (frame_addr <= MAX_ADDR);
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         bit_cnt_q <= '0;
         shift_q   <= '0;
      end else begin
         state_q <= state_nxt;
         if (clr_frame) begin
            bit_cnt_q <= '0;
            shift_q   <= '0;
         end else if (do_shift) begin
            bit_cnt_q <= bit_cnt_q + 1'b1;
            shift_q   <= {shift_q[FRAME_BITS-2:0], copi_s};
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         en_out_lo_q <= 8'h00;
         en_out_hi_q <= 8'h00;
         en_pwm_lo_q <= 8'h00;
         en_pwm_hi_q <= 8'h00;
         duty_q      <= 8'h00;
         wr_done_q   <= 1'b0;
      end else begin
         wr_done_q <= do_commit;
         if (do_commit) begin
            case (frame_addr)
               ADDR_EN_OUT_LO: en_out_lo_q <= frame_data;
               ADDR_EN_OUT_HI: en_out_hi_q <= frame_data;
               ADDR_EN_PWM_LO: en_pwm_lo_q <= frame_data;
               ADDR_EN_PWM_HI: en_pwm_hi_q <= frame_data;
               ADDR_DUTY:      duty_q      <= frame_data;
               default: ;
            endcase
         end
      end
   end

   assign bus.en_reg_out_7_0  = en_out_lo_q;
   assign bus.en_reg_out_15_8 = en_out_hi_q;
   assign bus.en_reg_pwm_7_0  = en_pwm_lo_q;
   assign bus.en_reg_pwm_15_8 = en_pwm_hi_q;
   assign bus.pwm_duty_cycle  = duty_q;
   assign bus.wr_done         = wr_done_q;
   assign state_dbg           = state_q;

endmodule

// File: tb/tb_spi_pwm_config.sv
// Directed bench for spi_pwm_config: SPI frames at clk/8 with hand-computed register expectations.
module tb_spi_pwm_config;
   import spi_pwm_pkg::*;

   localparam int SYNC_STAGES = 2;

   logic       clk;
   logic       rst_n;
   spi_state_e state_dbg;
   int         checks;
   int         errors;
   int         pulses;
   int         first_at;
   logic [7:0] exp_reg [5];

   spi_pwm_if bus ();

   spi_pwm_config #(.SYNC_STAGES(SYNC_STAGES), .MAX_ADDR(7'h04)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .bus       (bus),
      .state_dbg (state_dbg)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_regs(input string tag);
      check({tag, "_en_out_lo"}, {8'h00, bus.en_reg_out_7_0},  {8'h00, exp_reg[0]});
      check({tag, "_en_out_hi"}, {8'h00, bus.en_reg_out_15_8}, {8'h00, exp_reg[1]});
      check({tag, "_en_pwm_lo"}, {8'h00, bus.en_reg_pwm_7_0},  {8'h00, exp_reg[2]});
      check({tag, "_en_pwm_hi"}, {8'h00, bus.en_reg_pwm_15_8}, {8'h00, exp_reg[3]});
      check({tag, "_duty"},      {8'h00, bus.pwm_duty_cycle},  {8'h00, exp_reg[4]});
   endtask

   // Drive one frame of nbits (bits past 16 send 1) and watch wr_done for 10 cycles after ncs rises.
   task automatic spi_xfer(input logic [15:0] frame, input int nbits,
                           output int n_pulses, output int first_cycle);
      bus.ncs = 1'b0;
      repeat (4) @(negedge clk);
      for (int i = 0; i < nbits; i++) begin
         bus.copi = (i < 16) ? frame[15-i] : 1'b1;
         repeat (4) @(negedge clk);
         bus.sclk = 1'b1;
         repeat (4) @(negedge clk);
         bus.sclk = 1'b0;
      end
      repeat (4) @(negedge clk);
      bus.ncs = 1'b1;
      n_pulses    = 0;
      first_cycle = 0;
      for (int k = 1; k <= 10; k++) begin
         @(posedge clk);
         #1;
         if (bus.wr_done === 1'b1) begin
            n_pulses++;
            if (first_cycle == 0) first_cycle = k;
         end
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      for (int i = 0; i < 5; i++) exp_reg[i] = 8'h00;
      bus.sclk = 1'b0;
      bus.copi = 1'b0;
      bus.ncs  = 1'b1;
      rst_n    = 1'b0;

      // 1: reset, then sclk toggling with ncs high must not disturb anything
      repeat (5) @(negedge clk);
      check("rst_wr_done", {15'd0, bus.wr_done}, 16'd0);
      check("rst_state", {14'd0, state_dbg}, {14'd0, ST_IDLE});
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         bus.copi = 1'b1;
         repeat (3) @(negedge clk);
         bus.sclk = ~bus.sclk;
         if (bus.wr_done === 1'b1) pulses = 99;
      end
      bus.sclk = 1'b0;
      repeat (4) @(negedge clk);
      check_regs("idle_sclk");
      check("idle_sclk_state", {14'd0, state_dbg}, {14'd0, ST_IDLE});

      // 2: write 0xF0 to address 0x00
      spi_xfer(16'h80F0, 16, pulses, first_at);
      exp_reg[0] = 8'hF0;
      check("w00_pulses", 16'(pulses), 16'd1);
      check("w00_latency_ok", {15'd0, (first_at >= 1) && (first_at <= SYNC_STAGES + 3)}, 16'd1);
      check_regs("w00");

      // 3: duty cycle write, then a read frame to the same address
      spi_xfer(16'h8480, 16, pulses, first_at);
      exp_reg[4] = 8'h80;
      check("w04_pulses", 16'(pulses), 16'd1);
      check_regs("w04");
      spi_xfer(16'h0455, 16, pulses, first_at);
      check("rd04_pulses", 16'(pulses), 16'd0);
      check_regs("rd04");

      // 4: address above MAX_ADDR
      spi_xfer(16'h8755, 16, pulses, first_at);
      check("w07_pulses", 16'(pulses), 16'd0);
      check_regs("w07");

      // 5: truncated frame discarded, following full frame accepted
      spi_xfer(16'h8233, 12, pulses, first_at);
      check("trunc_pulses", 16'(pulses), 16'd0);
      check_regs("trunc");
      spi_xfer(16'h8233, 16, pulses, first_at);
      exp_reg[2] = 8'h33;
      check("w02_pulses", 16'(pulses), 16'd1);
      check_regs("w02");

      // 6: 17-bit frame keeps the first 16 bits
      spi_xfer(16'h83A5, 17, pulses, first_at);
      exp_reg[3] = 8'hA5;
      check("w03_17b_pulses", 16'(pulses), 16'd1);
      check_regs("w03_17b");

      // 6b: reset mid-frame clears everything immediately
      bus.ncs = 1'b0;
      repeat (4) @(negedge clk);
      for (int i = 0; i < 5; i++) begin
         bus.copi = 1'b1;
         repeat (4) @(negedge clk);
         bus.sclk = 1'b1;
         repeat (4) @(negedge clk);
         bus.sclk = 1'b0;
      end
      check("midframe_state", {14'd0, state_dbg}, {14'd0, ST_SHIFT});
      rst_n = 1'b0;
      #1;
      for (int i = 0; i < 5; i++) exp_reg[i] = 8'h00;
      check_regs("midrst");
      check("midrst_state", {14'd0, state_dbg}, {14'd0, ST_IDLE});
      repeat (3) @(negedge clk);
      bus.ncs  = 1'b1;
      bus.sclk = 1'b0;
      rst_n    = 1'b1;
      pulses   = 0;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         if (bus.wr_done === 1'b1) pulses++;
      end
      check("post_rst_pulses", 16'(pulses), 16'd0);
      check("post_rst_state", {14'd0, state_dbg}, {14'd0, ST_IDLE});

      // still functional after the abort
      spi_xfer(16'h8155, 16, pulses, first_at);
      exp_reg[1] = 8'h55;
      check("w01_pulses", 16'(pulses), 16'd1);
      check_regs("w01");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
